soc_rst_ctrl: RTL and testbench
===============================

Name: soc_rst_ctrl

Overview:
- Reset sequencer between the PLL/board pins and the tinyriscv SoC.
- Holds the SoC in reset until the PLL has been locked and stable for a programmed time, then releases core and peripheral resets in a staged order.
- Re-enters reset on PLL lock loss, a debounced external button press, a JTAG reset request or a software reset request.
- Records which of those caused the most recent reset.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on pll_lock_i and rst_btn_i (min 2).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronized lock required before leaving WAIT_LOCK.
- DEBOUNCE_CYCLES, 50000, consecutive cycles the button must be active before it is accepted.
- CORE_HOLD_CYCLES, 16, cycles the core reset stays asserted after peripheral reset release.
- BTN_ACTIVE_LOW, 1, 1 = rst_btn_i is active-low (board convention), 0 = active-high.

Ports:
- clk, input, 1, PLL output clock.
- rst, input, 1, synchronous active-high power-on reset.
- pll_lock_i, input, 1, PLL lock, asynchronous.
- rst_btn_i, input, 1, external reset button, asynchronous; polarity set by BTN_ACTIVE_LOW.
- jtag_rst_req_i, input, 1, single-cycle reset request from the debug module, clk domain.
- sw_rst_req_i, input, 1, single-cycle reset request from a peripheral register, clk domain.
- periph_rst_n_o, output, 1, active-low reset to bus/peripherals.
- core_rst_n_o, output, 1, active-low reset to the CPU core.
- ready_o, output, 1, high in RUN only.
- rst_cause_o, output, 4, sticky one-hot cause: [0] lock loss/power-on, [1] button, [2] jtag, [3] sw.

Behaviour:
- Synchronous active-high reset; clock domain clk only.
- rst=1 effects:
  - state=WAIT_LOCK; periph_rst_n_o=0, core_rst_n_o=0, ready_o=0, rst_cause_o=4'b0001.
  - All counters and synchronizer flops cleared; the button sync clears to the inactive level.
- Inputs pll_lock_i and rst_btn_i pass through SYNC_STAGES flops; only the synchronized values are used. lock_s denotes the synchronized lock.
- Button debounce:
  - Counter increments while the synchronized button is active and clears when inactive.
  - btn_evt is asserted for one cycle when the counter reaches DEBOUNCE_CYCLES-1; the counter saturates at that value.
  - A new event requires release and a fresh full debounce.
- States:
  - WAIT_LOCK: both resets asserted; stable counter increments while lock_s=1 and clears when lock_s=0. At count LOCK_STABLE_CYCLES-1 with lock_s=1, go to PERIPH_REL.
  - PERIPH_REL: lasts exactly 1 cycle; periph_rst_n_o goes to 1 on entry; go to CORE_HOLD with the hold counter cleared.
  - CORE_HOLD: periph released, core held; the hold counter counts to CORE_HOLD_CYCLES-1, then go to RUN.
  - RUN: both resets deasserted; ready_o=1.
  - Outputs are registered; each takes the value of the state it is entering, in the same cycle as the state register.
- Reset triggers (lock_s=0, btn_evt, jtag_rst_req_i, sw_rst_req_i):
  - Act in every state except WAIT_LOCK.
  - Next cycle: state=WAIT_LOCK, both resets asserted, ready_o=0, all counters cleared.
  - In WAIT_LOCK, triggers other than lock_s=0 are ignored, and rst_cause_o is not changed.
- Cause recording:
  - rst_cause_o is written only on a transition into WAIT_LOCK and holds all other times.
  - Simultaneous triggers set all of their bits together.
  - Bit 0 is set only if lock_s=0 was one of the triggers.
- Latency:
  - First lock_s high in WAIT_LOCK to periph release: LOCK_STABLE_CYCLES cycles.
  - periph release to core release: 1 + CORE_HOLD_CYCLES cycles.
- Lock glitch during WAIT_LOCK restarts the stable count from 0; a partial count is never retained.
- jtag/sw request pulses longer than one cycle are treated as a single request. A still-high request after re-entry to WAIT_LOCK has no effect.

Decomposition:
- Shared package soc_rst_pkg holds:
  - State encoding constants: WAIT_LOCK=2'd0, PERIPH_REL=2'd1, CORE_HOLD=2'd2, RUN=2'd3.
  - Cause-bit index constants CAUSE_LOCK=0, CAUSE_BTN=1, CAUSE_JTAG=2, CAUSE_SW=3.
- One sub-module, rst_debounce: synchronizer plus debounce counter, parameterized by SYNC_STAGES, DEBOUNCE_CYCLES and BTN_ACTIVE_LOW, producing the single-cycle btn_evt.
- The pll_lock synchronizer is a plain flop chain inside the top.

Test Plan (LOCK_STABLE_CYCLES=8, DEBOUNCE_CYCLES=4, CORE_HOLD_CYCLES=3, SYNC_STAGES=2):
- Power-up: rst high for 5 cycles, lock=1 from cycle 0 → periph_rst_n_o rises 8 cycles after lock_s rises; core_rst_n_o and ready_o rise 4 cycles later; rst_cause_o=0001.
- Lock glitch: lock low for 1 cycle at stable count 5 in WAIT_LOCK → count restarts; release occurs 8 cycles after lock_s returns high.
- Button: in RUN, hold rst_btn_i=0 for 3 cycles then release → no reset. Hold it for 6 cycles → one WAIT_LOCK entry with rst_cause_o=0010; sequence re-runs because lock is held.
- Simultaneous: in RUN, jtag_rst_req_i and sw_rst_req_i pulse high in the same cycle → rst_cause_o=1100; both resets asserted the next cycle.
- Lock loss in CORE_HOLD: drop lock at hold count 1 → core never releases; periph_rst_n_o returns to 0 the next cycle; rst_cause_o=0001.
- Mid-operation rst: assert rst while in RUN → all outputs reach their reset values the next edge; button debounce state cleared.

Source files
------------

// File: rtl/soc_rst_pkg.sv
// Shared definitions for the SoC reset sequencer: state encoding,
// reset-cause bit positions and a counter-width helper.
package soc_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    PERIPH_REL = 2'd1,
    CORE_HOLD  = 2'd2,
    RUN        = 2'd3
  } rst_state_e;

  localparam int unsigned CAUSE_LOCK = 0;
  localparam int unsigned CAUSE_BTN  = 1;
  localparam int unsigned CAUSE_JTAG = 2;
  localparam int unsigned CAUSE_SW   = 3;
  localparam int unsigned CAUSE_W    = 4;

  // Cause reported after power-on reset: treated as a lock loss.
  localparam logic [CAUSE_W-1:0] CAUSE_POR = 4'b0001;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Reset button synchronizer and debouncer. Emits a single-cycle btn_evt
// once the button has been continuously active for DEBOUNCE_CYCLES cycles;
// a further event needs a release and a fresh full debounce.
module rst_debounce
  import soc_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_evt
);

  localparam int unsigned    DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic           BTN_IDLE = BTN_ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q;
  logic                   fired_q;
  logic                   btn_act;

  // Synchronizer chain; clears to the button's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{BTN_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign btn_act = sync_q[SYNC_STAGES-1] ^ BTN_IDLE;

  // The counter saturates at DB_LAST; fired_q keeps the event to one cycle.
  assign btn_evt = btn_act && (cnt_q == DB_LAST) && !fired_q;

  // Debounce counter: runs while active, cleared on release.
  always_ff @(posedge clk) begin
    if (rst || !btn_act) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      if (cnt_q != DB_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (btn_evt) begin
        fired_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_rst_ctrl.sv
// Reset sequencer for the tinyriscv SoC: waits for a stable PLL lock,
// releases peripheral reset, then core reset after a hold time, and
// re-enters reset on lock loss, button, JTAG or software request.
module soc_rst_ctrl
  import soc_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DEBOUNCE_CYCLES    = 50000,
  parameter int unsigned CORE_HOLD_CYCLES   = 16,
  parameter bit          BTN_ACTIVE_LOW     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_i,
  input  logic               rst_btn_i,
  input  logic               jtag_rst_req_i,
  input  logic               sw_rst_req_i,
  output logic               periph_rst_n_o,
  output logic               core_rst_n_o,
  output logic               ready_o,
  output logic [CAUSE_W-1:0] rst_cause_o
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > CORE_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : CORE_HOLD_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CORE_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   btn_evt;
  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CAUSE_W-1:0]     cause_d;
  logic [CAUSE_W-1:0]     trig;
  logic                   periph_d, core_d;

  rst_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (rst_btn_i),
    .btn_evt(btn_evt)
  );

  // PLL lock synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Reset triggers, laid out in cause-bit order.
  always_comb begin
    trig             = '0;
    trig[CAUSE_LOCK] = !lock_s;
    trig[CAUSE_BTN]  = btn_evt;
    trig[CAUSE_JTAG] = jtag_rst_req_i;
    trig[CAUSE_SW]   = sw_rst_req_i;
  end

  // Next state, shared stable/hold counter, cause and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = rst_cause_o;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = PERIPH_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PERIPH_REL: begin
        state_d = CORE_HOLD;
        cnt_d   = '0;
      end
      CORE_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Triggers override the sequence everywhere but WAIT_LOCK, and the
    // cause is only rewritten on that transition.
    if ((state_q != WAIT_LOCK) && (|trig)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      cause_d = trig;
    end
    periph_d = (state_d != WAIT_LOCK);
    core_d   = (state_d == RUN);
  end

  // State, counter, cause and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      rst_cause_o    <= CAUSE_POR;
      periph_rst_n_o <= 1'b0;
      core_rst_n_o   <= 1'b0;
      ready_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rst_cause_o    <= cause_d;
      periph_rst_n_o <= periph_d;
      core_rst_n_o   <= core_d;
      ready_o        <= core_d;
    end
  end

endmodule

// File: tb/tb_soc_rst_ctrl.sv
// Self-checking bench for soc_rst_ctrl: a timestamp-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_soc_rst_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned LOCK = 8;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 3;

  logic       clk;
  logic       rst;
  logic       pll_lock_i;
  logic       rst_btn_i;
  logic       jtag_rst_req_i;
  logic       sw_rst_req_i;
  logic       periph_rst_n_o;
  logic       core_rst_n_o;
  logic       ready_o;
  logic [3:0] rst_cause_o;

  int errors = 0;
  int checks = 0;

  soc_rst_ctrl #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LOCK),
    .DEBOUNCE_CYCLES   (DB),
    .CORE_HOLD_CYCLES  (HOLD),
    .BTN_ACTIVE_LOW    (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock_i    (pll_lock_i),
    .rst_btn_i     (rst_btn_i),
    .jtag_rst_req_i(jtag_rst_req_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .periph_rst_n_o(periph_rst_n_o),
    .core_rst_n_o  (core_rst_n_o),
    .ready_o       (ready_o),
    .rst_cause_o   (rst_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Tracks whether the SoC is waiting for lock and the
  // edge at which the peripherals were released; the core is released a
  // fixed time after that edge.
  int         cyc = 0;
  bit         m_valid = 0;
  bit         m_seek = 1;
  int         lock_run = 0;
  int         btn_run = 0;
  int         rel_cyc = 0;
  logic [SYNC-1:0] lock_pipe = '0;
  logic [SYNC-1:0] btn_pipe = '1;
  logic [3:0] m_cause = 4'b0001;

  always @(posedge clk) begin
    logic       ls, ba, evt;
    logic [3:0] trig;
    cyc++;
    if (rst) begin
      m_valid   = 1;
      m_seek    = 1;
      lock_run  = 0;
      btn_run   = 0;
      lock_pipe = '0;
      btn_pipe  = '1;
      m_cause   = 4'b0001;
    end else begin
      ls  = lock_pipe[SYNC-1];
      ba  = !btn_pipe[SYNC-1];
      evt = ba && (btn_run + 1 == int'(DB));
      btn_run = ba ? btn_run + 1 : 0;
      trig = {sw_rst_req_i, jtag_rst_req_i, evt, !ls};
      if (m_seek) begin
        if (ls) begin
          lock_run++;
          if (lock_run == int'(LOCK)) begin
            m_seek   = 0;
            rel_cyc  = cyc;
            lock_run = 0;
          end
        end else begin
          lock_run = 0;
        end
      end else if (trig != 4'b0000) begin
        m_seek   = 1;
        lock_run = 0;
        m_cause  = trig;
      end
      lock_pipe = {lock_pipe[SYNC-2:0], pll_lock_i};
      btn_pipe  = {btn_pipe[SYNC-2:0], rst_btn_i};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_core;
      exp_core = !m_seek && (cyc >= rel_cyc + 1 + int'(HOLD));
      chk("model_periph", 4'(periph_rst_n_o), 4'(!m_seek));
      chk("model_core",   4'(core_rst_n_o),   4'(exp_core));
      chk("model_ready",  4'(ready_o),        4'(exp_core));
      chk("model_cause",  rst_cause_o,        m_cause);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int k = 0;
    while (ready_o !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 4'(ready_o), 4'b0001);
  endtask

  initial begin
    rst            = 1'b1;
    pll_lock_i     = 1'b1;
    rst_btn_i      = 1'b1;
    jtag_rst_req_i = 1'b0;
    sw_rst_req_i   = 1'b0;

    // Power-up
    step(5);
    chk("por_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("por_core",   4'(core_rst_n_o),   4'b0000);
    chk("por_ready",  4'(ready_o),        4'b0000);
    chk("por_cause",  rst_cause_o,        4'b0001);
    rst = 1'b0;
    // lock_s high after 2 edges, then 8 stable edges
    step(9);
    chk("pu_periph_before", 4'(periph_rst_n_o), 4'b0000);
    step(1);
    chk("pu_periph_rel", 4'(periph_rst_n_o), 4'b0001);
    step(3);
    chk("pu_core_before", 4'(core_rst_n_o), 4'b0000);
    step(1);
    chk("pu_core_rel", 4'(core_rst_n_o), 4'b0001);
    chk("pu_ready",    4'(ready_o),      4'b0001);
    chk("pu_cause",    rst_cause_o,      4'b0001);

    // Button: short press ignored, long press resets
    step(2);
    rst_btn_i = 1'b0;
    step(3);
    rst_btn_i = 1'b1;
    step(8);
    chk("btn_short_periph", 4'(periph_rst_n_o), 4'b0001);
    chk("btn_short_ready",  4'(ready_o),        4'b0001);
    rst_btn_i = 1'b0;
    step(5);
    chk("btn_long_pre", 4'(periph_rst_n_o), 4'b0001);
    step(1);
    rst_btn_i = 1'b1;
    chk("btn_long_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("btn_long_cause",  rst_cause_o,        4'b0010);
    wait_ready(40, "btn_rerun_ready");
    chk("btn_cause_held", rst_cause_o, 4'b0010);

    // Lock loss in RUN, then lock glitch during WAIT_LOCK
    pll_lock_i = 1'b0;
    step(4);
    chk("loss_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("loss_cause",  rst_cause_o,        4'b0001);
    pll_lock_i = 1'b1;
    step(7);
    pll_lock_i = 1'b0;
    step(1);
    pll_lock_i = 1'b1;
    step(9);
    chk("glitch_no_early_rel", 4'(periph_rst_n_o), 4'b0000);
    step(1);
    chk("glitch_rel", 4'(periph_rst_n_o), 4'b0001);

    // Lock loss at hold count 1 in CORE_HOLD
    pll_lock_i = 1'b0;
    step(2);
    chk("hold_periph_still", 4'(periph_rst_n_o), 4'b0001);
    chk("hold_core_held",    4'(core_rst_n_o),   4'b0000);
    step(1);
    chk("hold_loss_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("hold_loss_core",   4'(core_rst_n_o),   4'b0000);
    chk("hold_loss_cause",  rst_cause_o,        4'b0001);
    step(3);
    chk("hold_core_never", 4'(core_rst_n_o), 4'b0000);
    pll_lock_i = 1'b1;
    wait_ready(40, "hold_rerun_ready");

    // Simultaneous jtag and sw requests
    jtag_rst_req_i = 1'b1;
    sw_rst_req_i   = 1'b1;
    step(1);
    jtag_rst_req_i = 1'b0;
    sw_rst_req_i   = 1'b0;
    chk("sim_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("sim_core",   4'(core_rst_n_o),   4'b0000);
    chk("sim_cause",  rst_cause_o,        4'b1100);
    wait_ready(40, "sim_rerun_ready");

    // Two-cycle sw request counts once
    sw_rst_req_i = 1'b1;
    step(2);
    sw_rst_req_i = 1'b0;
    chk("sw_long_cause", rst_cause_o, 4'b1000);
    wait_ready(40, "sw_rerun_ready");

    // Mid-operation reset with the button partly debounced
    rst_btn_i = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    chk("mid_periph", 4'(periph_rst_n_o), 4'b0000);
    chk("mid_core",   4'(core_rst_n_o),   4'b0000);
    chk("mid_ready",  4'(ready_o),        4'b0000);
    chk("mid_cause",  rst_cause_o,        4'b0001);
    rst_btn_i = 1'b1;
    step(1);
    rst = 1'b0;
    wait_ready(40, "mid_rerun_ready");
    chk("mid_cause_after", rst_cause_o, 4'b0001);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
